mult_div_unit: RTL and testbench



---
 rtl/mult_div_unit.sv | 154 +++++++++++++++
 tb/tb_mult_div_unit.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/mult_div_unit.sv
// Multi-cycle shift-add multiply / restoring divide unit owning the hi/lo pair.
// Optional feature macro MULTDIV_MTHILO_EN adds mt_hi/mt_lo direct writes of hi/lo from inA.
module mult_div_unit #(
  parameter int WIDTH = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] inA,
  input  logic [WIDTH-1:0] inB,
`ifdef MULTDIV_MTHILO_EN
  input  logic             mt_hi,
  input  logic             mt_lo,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIX
  } state_t;

  state_t             state;
  logic [CW-1:0]      cnt;
  logic               is_div;
  logic               neg_q;
  logic               neg_r;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   rem;
  logic [WIDTH-1:0]   quo;

  logic               sign_a;
  logic               sign_b;
  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   mag_b;
  logic               b_zero;
  logic [WIDTH-1:0]   add_a;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH-1:0]   div_diff;
  logic               div_ge;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;

  // NOTE: every signal in this block is assigned on every path, so no latch is inferred.
  always_comb begin
    sign_a    = ~op[0] & inA[WIDTH-1];
    sign_b    = ~op[0] & inB[WIDTH-1];
    mag_a     = sign_a ? -inA : inA;
    mag_b     = sign_b ? -inB : inB;
    b_zero    = (inB == '0);
    add_a     = acc[0] ? a_mag : '0;
    mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, add_a};
    div_shift = {rem, quo[WIDTH-1]};
    div_ge    = (div_shift >= {1'b0, b_mag});
    // Only used when div_ge holds, where the true difference fits in WIDTH bits.
    div_diff  = div_shift[WIDTH-1:0] - b_mag;
    prod_fix  = neg_q ? -acc : acc;
    quo_fix   = neg_q ? -quo : quo;
    rem_fix   = neg_r ? -rem : rem;
  end

  // NOTE: non-blocking assignments throughout, so every branch sees pre-edge state.
  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      hi          <= '0;
      lo          <= '0;
      div_by_zero <= 1'b0;
      is_div      <= 1'b0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
      a_mag       <= '0;
      b_mag       <= '0;
      acc         <= '0;
      rem         <= '0;
      quo         <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
`ifdef MULTDIV_MTHILO_EN
          if (mt_hi || mt_lo) begin
            if (mt_hi) hi <= inA;
            if (mt_lo) lo <= inA;
          end else
`endif
          if (start) begin
            is_div      <= op[1];
            neg_q       <= sign_a ^ sign_b;
            neg_r       <= sign_a;
            a_mag       <= mag_a;
            b_mag       <= mag_b;
            acc         <= {{WIDTH{1'b0}}, mag_b};
            rem         <= '0;
            quo         <= mag_a;
            cnt         <= '0;
            busy        <= 1'b1;
            div_by_zero <= op[1] & b_zero;
            state       <= (op[1] && b_zero) ? FIX : RUN;
          end
        end

        RUN: begin
          if (is_div) begin
            rem <= div_ge ? div_diff : div_shift[WIDTH-1:0];
            quo <= {quo[WIDTH-2:0], div_ge};
          end else begin
            acc <= {mul_sum, acc[WIDTH-1:1]};
          end
          cnt <= cnt + CW'(1);
          if (cnt == CW'(WIDTH - 1)) state <= FIX;
        end

        FIX: begin
          // A divide by zero enters with cnt==0 and lingers one cycle, so done lands after E2.
          if (div_by_zero && cnt == '0) begin
            cnt <= CW'(1);
          end else begin
            if (!div_by_zero) begin
              if (is_div) begin
                hi <= rem_fix;
                lo <= quo_fix;
              end else begin
                hi <= prod_fix[2*WIDTH-1:WIDTH];
                lo <= prod_fix[WIDTH-1:0];
              end
            end
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed cases plus randomized ops
// against an arithmetic reference model (plain signed/unsigned * / %).
module tb_mult_div_unit;

  localparam int W = 16;

  logic         clock = 1'b0;
  logic         reset;
  logic         start;
  logic [1:0]   op;
  logic [W-1:0] inA;
  logic [W-1:0] inB;
  logic         busy;
  logic         done;
  logic [W-1:0] hi;
  logic [W-1:0] lo;
  logic         div_by_zero;

  int           checks = 0;
  int           errors = 0;
  logic [W-1:0] exp_hi = '0;
  logic [W-1:0] exp_lo = '0;
  logic         exp_dbz = 1'b0;
  int           exp_lat = 0;

  always #5 clock = ~clock;

  mult_div_unit #(.WIDTH(W)) dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .op          (op),
    .inA         (inA),
    .inB         (inB),
`ifdef MULTDIV_MTHILO_EN
    .mt_hi       (1'b0),
    .mt_lo       (1'b0),
`endif
    .busy        (busy),
    .done        (done),
    .hi          (hi),
    .lo          (lo),
    .div_by_zero (div_by_zero)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Expected result from plain integer arithmetic; SV / and % truncate toward zero.
  task automatic model(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    longint sa, sb, p, q, r;
    sa      = longint'($signed(a));
    sb      = longint'($signed(b));
    exp_lat = W + 1;
    exp_dbz = 1'b0;
    case (o)
      2'b00: begin p = sa * sb; {exp_hi, exp_lo} = p[2*W-1:0]; end
      2'b01: begin p = longint'(a) * longint'(b); {exp_hi, exp_lo} = p[2*W-1:0]; end
      default: begin
        if (b == '0) begin
          exp_dbz = 1'b1;
          exp_lat = 2;
        end else begin
          if (o == 2'b10) begin
            q = sa / sb;
            r = sa % sb;
          end else begin
            q = longint'(a) / longint'(b);
            r = longint'(a) % longint'(b);
          end
          exp_lo = q[W-1:0];
          exp_hi = r[W-1:0];
        end
      end
    endcase
  endtask

  task automatic run_op(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                        input bit poke);
    logic [W-1:0] prev_hi, prev_lo;
    int lat, busy_cycles;
    bit seen;
    prev_hi = exp_hi;
    prev_lo = exp_lo;
    model(o, a, b);
    @(negedge clock);
    start = 1'b1; op = o; inA = a; inB = b;
    @(posedge clock); #1;
    start = 1'b0; op = 2'($urandom); inA = W'($urandom); inB = W'($urandom);
    check("dbz_at_accept", div_by_zero, exp_dbz);
    busy_cycles = busy ? 1 : 0;
    lat = 0;
    seen = 1'b0;
    for (int n = 1; n <= 40 && !seen; n++) begin
      @(posedge clock); #1;
      start = 1'b0;
      if (done) begin
        seen = 1'b1;
        lat  = n;
      end else begin
        if (busy) busy_cycles++;
        if (n == 3) begin
          check("hi_hold_midrun", hi, prev_hi);
          check("lo_hold_midrun", lo, prev_lo);
        end
        // Stray starts while busy must be ignored.
        if (poke && n >= 2 && n <= 6) begin
          start = 1'b1; op = 2'($urandom); inA = W'($urandom); inB = W'($urandom);
        end
      end
    end
    start = 1'b0;
    check("latency", 64'(lat), 64'(exp_lat));
    check("busy_cycles", 64'(busy_cycles), 64'(exp_lat));
    check("busy_in_done", busy, 1'b0);
    check("hi", hi, exp_hi);
    check("lo", lo, exp_lo);
    check("div_by_zero", div_by_zero, exp_dbz);
  endtask

  task automatic idle_check(input int n);
    @(posedge clock); #1;
    check("done_one_cycle", done, 1'b0);
    check("dbz_sticky", div_by_zero, exp_dbz);
    repeat (n - 1) @(posedge clock);
    #1;
  endtask

  task automatic reset_mid_run();
    int done_seen;
    model(2'b00, W'($urandom), W'($urandom));
    @(negedge clock);
    start = 1'b1; op = 2'b00; inA = W'($urandom); inB = W'($urandom);
    @(posedge clock); #1;
    start = 1'b0;
    repeat (4) @(posedge clock);
    #1;
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    exp_hi = '0; exp_lo = '0; exp_dbz = 1'b0;
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_hi", hi, exp_hi);
    check("rst_lo", lo, exp_lo);
    done_seen = 0;
    for (int n = 0; n < 25; n++) begin
      @(posedge clock); #1;
      if (done) done_seen++;
    end
    check("rst_no_done", 64'(done_seen), 64'd0);
    check("rst_hi_after", hi, exp_hi);
  endtask

  initial begin
    logic [1:0]   ro;
    logic [W-1:0] ra, rb;
    reset = 1'b1; start = 1'b0; op = '0; inA = '0; inB = '0;
    repeat (3) @(posedge clock);
    #1;
    check("reset_busy", busy, 1'b0);
    check("reset_done", done, 1'b0);
    check("reset_hi", hi, 16'h0000);
    check("reset_lo", lo, 16'h0000);
    check("reset_dbz", div_by_zero, 1'b0);
    @(negedge clock);
    reset = 1'b0;

    run_op(2'b00, 16'hFFFD, 16'h0005, 1'b0);
    check("smul_hi_const", hi, 16'hFFFF);
    check("smul_lo_const", lo, 16'hFFF1);
    run_op(2'b01, 16'hFFFF, 16'hFFFF, 1'b0);
    check("umul_hi_const", hi, 16'hFFFE);
    run_op(2'b00, 16'hFFFF, 16'hFFFF, 1'b0);
    check("smul1_lo_const", lo, 16'h0001);
    run_op(2'b10, 16'hFFF9, 16'h0002, 1'b0);
    check("sdiv_lo_const", lo, 16'hFFFD);
    check("sdiv_hi_const", hi, 16'hFFFF);
    run_op(2'b11, 16'd100, 16'd7, 1'b0);
    check("udiv_lo_const", lo, 16'h000E);
    run_op(2'b10, 16'h8000, 16'hFFFF, 1'b0);
    check("ovf_lo_const", lo, 16'h8000);

    // Preload a distinctive hi/lo, then a divide by zero must leave it untouched.
    run_op(2'b01, 16'h1234, 16'h5678, 1'b0);
    run_op(2'b11, 16'h4321, 16'h0000, 1'b0);
    idle_check(3);
    run_op(2'b01, 16'h0003, 16'h0004, 1'b0);
    idle_check(2);

    run_op(2'b01, 16'hBEEF, 16'h1357, 1'b1);
    run_op(2'b10, 16'h8001, 16'h0003, 1'b1);

    reset_mid_run();

    for (int i = 0; i < 60; i++) begin
      ro = 2'($urandom_range(0, 3));
      ra = W'($urandom);
      rb = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
      if ($urandom_range(0, 9) == 0) begin
        ra = 16'h8000;
        rb = 16'hFFFF;
      end
      run_op(ro, ra, rb, ($urandom_range(0, 3) == 0) && (rb != '0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
